// File: rtl/encoder_pt2262_if.sv
// Encoder-side handshake: request, latched payload and serial output.
interface encoder_pt2262_if;
  logic       start;
  logic [7:0] A_01;
  logic [7:0] A_F;
  logic [3:0] D;
  logic       cod_o;
  logic       busy;
  logic       done;

  modport master (output start, A_01, A_F, D, input cod_o, busy, done);
  modport slave  (input start, A_01, A_F, D, output cod_o, busy, done);
endinterface

// File: rtl/encoder_pt2262.sv
// PT2262-style tri-state encoder: 8 address trits + 4 data bits, PWM coded,
// sync-terminated, repeated N_FRAMES times. Alpha timing from a DIV tick.
module encoder_pt2262 #(
  parameter int DIV      = 250,
  parameter int N_FRAMES = 4
) (
  input  logic             clk,
  input  logic             reset,
  encoder_pt2262_if.slave  bus
);

  localparam int DW = $clog2(DIV);
  localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(N_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BIT, S_SYNC} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [6:0]    alpha_q, alpha_d;
  logic [3:0]    bit_q, bit_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [7:0]    a01_q, a01_d;
  logic [7:0]    af_q, af_d;
  logic [3:0]    dat_q, dat_d;
  logic          cod_q, cod_d;
  logic          done_q, done_d;

  logic          tick;
  logic          sym_one, sym_f, sub_long;

  assign tick = (div_q == DIV_LAST);

  // Next-state, counters and registered output, evaluated on next-cycle values
  // so cod_o rises on the very edge that accepts a request.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    alpha_d = alpha_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    a01_d   = a01_q;
    af_d    = af_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    cod_d   = 1'b0;
    sym_one = 1'b0;
    sym_f   = 1'b0;
    sub_long = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_d   = '0;
        alpha_d = '0;
        bit_d   = '0;
        frame_d = '0;
        if (bus.start) begin
          a01_d   = bus.A_01;
          af_d    = bus.A_F;
          dat_d   = bus.D;
          state_d = S_BIT;
        end
      end
      S_BIT: begin
        if (tick) begin
          div_d = '0;
          if (alpha_q == 7'd31) begin
            alpha_d = '0;
            if (bit_q == 4'd11) state_d = S_SYNC;
            else                bit_d   = bit_q + 4'd1;
          end else begin
            alpha_d = alpha_q + 7'd1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_SYNC: begin
        if (tick) begin
          div_d = '0;
          if (alpha_q == 7'd127) begin
            alpha_d = '0;
            bit_d   = '0;
            if (frame_q == FRAME_LAST) begin
              state_d = S_IDLE;
              frame_d = '0;
              done_d  = 1'b1;
            end else begin
              frame_d = frame_q + FW'(1);
              state_d = S_BIT;
            end
          end else begin
            alpha_d = alpha_q + 7'd1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Symbol of the position being sent next cycle; float overrides A_01.
    if (bit_d < 4'd8) begin
      sym_f   = af_d[bit_d[2:0]];
      sym_one = ~sym_f & a01_d[bit_d[2:0]];
    end else begin
      sym_one = dat_d[bit_d[1:0]];
    end
    // F is short then long; 1 is long twice; 0 short twice.
    sub_long = sym_one | (sym_f & alpha_d[4]);

    case (state_d)
      S_BIT:   cod_d = (alpha_d[3:0] < (sub_long ? 4'd12 : 4'd4));
      S_SYNC:  cod_d = (alpha_d < 7'd4);
      default: cod_d = 1'b0;
    endcase
  end

  // State and counter registers, asynchronous abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      alpha_q <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      a01_q   <= '0;
      af_q    <= '0;
      dat_q   <= '0;
      cod_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      alpha_q <= alpha_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      a01_q   <= a01_d;
      af_q    <= af_d;
      dat_q   <= dat_d;
      cod_q   <= cod_d;
      done_q  <= done_d;
    end
  end

  assign bus.cod_o = cod_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_encoder_pt2262.sv
// Bench for encoder_pt2262: per-clk expected {cod_o,busy,done} pushed from a
// segment model when a request is issued, popped and compared every cycle.
module tb_encoder_pt2262;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  encoder_pt2262_if if1 ();
  encoder_pt2262_if if3 ();

  encoder_pt2262 #(.DIV(DIV), .N_FRAMES(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  encoder_pt2262 #(.DIV(DIV), .N_FRAMES(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  logic [2:0] obs1, obs3;
  assign obs1 = {if1.cod_o, if1.busy, if1.done};
  assign obs3 = {if3.cod_o, if3.busy, if3.done};

  // hi alpha high then lo alpha low, busy throughout
  task automatic push_seg(input int hi, input int lo);
    repeat (hi * DIV) exp_q.push_back(3'b110);
    repeat (lo * DIV) exp_q.push_back(3'b010);
  endtask

  // Whole transmission followed by the done cycle.
  task automatic push_tx(input int nf, input logic [7:0] a01, input logic [7:0] af,
                         input logic [3:0] d);
    logic one;
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < 12; i++) begin
        one = (i < 8) ? a01[i] : d[i-8];
        if (i < 8 && af[i]) begin push_seg(4, 12); push_seg(12, 4); end
        else if (one)       begin push_seg(12, 4); push_seg(12, 4); end
        else                begin push_seg(4, 12); push_seg(4, 12); end
      end
      push_seg(4, 124);
    end
    exp_q.push_back(3'b001);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if1.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (obs1 !== 3'b000 || obs3 !== 3'b000) begin
        fails++;
        $display("FAIL reset_hold k=%0d got=%b/%b exp=000", k, obs1, obs3);
      end
    end
    if1.start = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (obs1 !== 3'b000 || obs3 !== 3'b000) begin
        fails++;
        $display("FAIL reset_release k=%0d got=%b/%b exp=000", k, obs1, obs3);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [2:0] e;
    int hi = 0, bz = 0, dn = 0, k = 0;
    if1.A_01 = 8'h00; if1.A_F = 8'h00; if1.D = 4'h0;
    push_tx(1, 8'h00, 8'h00, 4'h0);
    exp_q.push_back(3'b000);
    if1.start = 1'b1;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if1.start = 1'b0;
      e = exp_q.pop_front();
      hi += obs1[2]; bz += obs1[1]; dn += obs1[0];
      checks++;
      if (obs1 !== e) begin
        fails++;
        $display("FAIL single k=%0d got=%b exp=%b", k, obs1, e);
      end
      k++;
    end
    checks++;
    if (hi !== 24*16 + 16) begin fails++; $display("FAIL single_high got=%0d exp=%0d", hi, 400); end
    checks++;
    if (bz !== 2048) begin fails++; $display("FAIL single_busy got=%0d exp=2048", bz); end
    checks++;
    if (dn !== 1) begin fails++; $display("FAIL single_done got=%0d exp=1", dn); end
  endtask

  task automatic test_symbols();
    logic [2:0] e;
    int k = 0;
    if1.A_01 = 8'hAA; if1.A_F = 8'h81; if1.D = 4'hF;
    push_tx(1, 8'hAA, 8'h81, 4'hF);
    exp_q.push_back(3'b000);
    if1.start = 1'b1;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if1.start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        fails++;
        $display("FAIL symbols k=%0d got=%b exp=%b", k, obs1, e);
      end
      k++;
    end
  endtask

  task automatic test_repetition();
    logic [2:0] e;
    int bz = 0, dn = 0, k = 0;
    if3.A_01 = 8'hC3; if3.A_F = 8'h18; if3.D = 4'h9;
    push_tx(3, 8'hC3, 8'h18, 4'h9);
    exp_q.push_back(3'b000);
    if3.start = 1'b1;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if3.start = 1'b0;
      e = exp_q.pop_front();
      bz += obs3[1]; dn += obs3[0];
      checks++;
      if (obs3 !== e) begin
        fails++;
        $display("FAIL repeat k=%0d got=%b exp=%b", k, obs3, e);
      end
      k++;
    end
    checks++;
    if (bz !== 6144) begin fails++; $display("FAIL repeat_busy got=%0d exp=6144", bz); end
    checks++;
    if (dn !== 1) begin fails++; $display("FAIL repeat_done got=%0d exp=1", dn); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    int k = 0;
    if1.A_01 = 8'h0F; if1.A_F = 8'h30; if1.D = 4'h5;
    push_tx(1, 8'h0F, 8'h30, 4'h5);
    push_tx(1, 8'h3C, 8'h00, 4'h3);
    exp_q.push_back(3'b000);
    if1.start = 1'b1;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        fails++;
        $display("FAIL b2b k=%0d got=%b exp=%b", k, obs1, e);
      end
      if (k == 0)   if1.start = 1'b0;
      if (k == 500) begin if1.start = 1'b1; if1.D = 4'hA; end
      if (k == 501) if1.start = 1'b0;
      if (k == 1000) begin if1.start = 1'b1; if1.A_01 = 8'h3C; if1.A_F = 8'h00; if1.D = 4'h3; end
      if (k == 2149) if1.start = 1'b0;
      k++;
    end
  endtask

  task automatic test_abort();
    logic [2:0] e;
    int k = 0;
    if1.A_01 = 8'hFF; if1.A_F = 8'h00; if1.D = 4'hF;
    push_tx(1, 8'hFF, 8'h00, 4'hF);
    if1.start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1;
      if1.start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        fails++;
        $display("FAIL abort_pre k=%0d got=%b exp=%b", n, obs1, e);
      end
    end
    exp_q.delete();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs1 !== 3'b000) begin fails++; $display("FAIL abort_async got=%b exp=000", obs1); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      checks++;
      if (obs1 !== 3'b000) begin fails++; $display("FAIL abort_idle n=%0d got=%b exp=000", n, obs1); end
    end
    if1.A_01 = 8'h5A; if1.A_F = 8'h24; if1.D = 4'h6;
    push_tx(1, 8'h5A, 8'h24, 4'h6);
    exp_q.push_back(3'b000);
    if1.start = 1'b1;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if1.start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        fails++;
        $display("FAIL abort_post k=%0d got=%b exp=%b", k, obs1, e);
      end
      k++;
    end
  endtask

  initial begin
    if1.start = 1'b0; if1.A_01 = '0; if1.A_F = '0; if1.D = '0;
    if3.start = 1'b0; if3.A_01 = '0; if3.A_F = '0; if3.D = '0;
    test_reset();
    test_single_frame();
    test_symbols();
    test_repetition();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/encoder_pt2262.md
# encoder_pt2262

PT2262-style tri-state remote-control encoder: the transmit end of the link received by the team's PT2272 decoder. On a start request it latches an 8-trit address (0/1/float) and a 4-bit data nibble. It serialises them onto `cod_o` as PWM-coded words, each closed by a sync symbol, and repeats the word a configurable number of times. Timing is derived from the 3 MHz system clock by a 12 kHz oscillator-tick enable; no derived clock is used.

## Interface
- `DIV`, default 250: clk cycles per oscillator period α (3 MHz / 250 = 12 kHz); legal range ≥ 2.
- `N_FRAMES`, default 4: number of word repetitions per transmission; legal range ≥ 1.
- `clk`  in  1  system clock, 3 MHz.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  transmission request; sampled only when `busy`=0.
- `A_01`  in  8  address bit value, per trit.
- `A_F`  in  8  address float flag; 1 = trit is F, overrides `A_01`.
- `D`  in  4  data nibble.
- `cod_o`  out  1  encoded serial output.
- `busy`  out  1  transmission in progress.
- `done`  out  1  one-cycle pulse when the last frame completes.

## Operation
- **States:**
  - IDLE: `cod_o`=0, `busy`=0.
  - BIT: transmits trit/bit `bit_idx`, 0..11.
  - SYNC: transmits the frame terminator.
- **Accept:** on the clk edge where `start`=1 and state=IDLE:
  - Latch `A_01`, `A_F` and `D`.
  - Clear all counters; set `bit_idx`=0 and `frame_cnt`=0.
  - Go to BIT.
  - Later changes on the inputs do not affect the transmission in progress.
- **Bit order:** A[0]..A[7], then D[0]..D[3]. Index 0 is transmitted first.
- **Symbol per position:** address trit = F if `A_F[i]`, else `A_01[i]`. Data bits are 0 or 1 only.
- **Bit period:** 32α, made of two 16α sub-pulses. Each sub-pulse is short (high 4α, low 12α) or long (high 12α, low 4α).
  - 0: short, short.
  - 1: long, long.
  - F: short, long.
- **Sync:** high 4α, low 124α (128α total).
- **Frame length:** 12×32 + 128 = 512α.
- **After SYNC:** if `frame_cnt` < `N_FRAMES`−1, increment `frame_cnt` and return to BIT with `bit_idx`=0. Otherwise return to IDLE and pulse `done`.
- **`start` while busy:** ignored; no queuing.
- **Counters:**
  - `div_cnt`: 0..DIV−1, wraps. It produces the α tick, which is asserted when `div_cnt`=DIV−1.
  - `alpha_cnt`: 0..31 in BIT, 0..127 in SYNC.
  - `bit_idx`: 0..11.
  - `frame_cnt`: 0..N_FRAMES−1.
  - All counters are cleared on accept and are held at 0 in IDLE.
- **`cod_o` is registered**, computed from state, `alpha_cnt` and the latched symbol:
  - BIT, with q = `alpha_cnt`[3:0] and sub-pulse = `alpha_cnt`[4]: high iff q<4 for a short sub-pulse, q<12 for a long one.
  - SYNC: high iff `alpha_cnt`<4.

## Timing
- **Reset values** (asynchronous, immediate): `cod_o`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- **Accept edge:** `busy` and `cod_o` both rise at the accept edge. The first α of trit 0 begins there (latency 1 clk from `start` sampled).
- **Segment durations:** every α segment lasts exactly DIV clk cycles. One frame = 512·DIV clk cycles; a transmission = N_FRAMES·512·DIV clk cycles.
- **End of transmission:** on the edge that ends the final sync's last α:
  - `busy` goes 0.
  - `done` goes 1 for exactly one cycle.
  - `cod_o` stays 0.
- **Back-to-back transmissions:** `start` is accepted on the clk edge after the `done` pulse (first cycle with `busy`=0). This gives a minimum gap of one clk at `cod_o`=0 beyond the sync low time.
- **Reset mid-transmission:** aborts immediately. `cod_o`, `busy` and `done` go to 0 with no partial frame completion and no `done` pulse.
- **Edge cases:** `start` held high continuously re-triggers each time IDLE is reached. A `start` coincident with `reset` is ignored.

## Test plan
- **Reset:** assert `reset` for 3 clk with `start`=1 → `cod_o`=0, `busy`=0, `done`=0 throughout; no transmission after release until a new `start` sample.
- **Single frame, DIV=4, N_FRAMES=1, `A_F`=0, `A_01`=8'h00, `D`=4'h0:**
  - Pulse `start` → `busy` for 2048 clk.
  - 24 high pulses of 16 clk, each followed by 48 clk low.
  - Sync: 16 clk high, 496 clk low.
  - `done` pulse at clk 2048 after accept.
- **Symbol coding, DIV=4:**
  - Address: `A_01`=8'hAA, `A_F`=8'h81, `D`=4'hF.
  - Sequence: trit0 F (16H/48L/48H/16L clk), trit1 1, trit2 0, …, trit7 F.
  - Data bits: all long-long (48H/16L twice).
- **Repetition, DIV=4, N_FRAMES=3:** three identical 2048-clk frames; a single `done` at clk 6144; `busy` continuous.
- **Busy/back-to-back:** `start` pulsed mid-frame with changed `D` → ignored, output unchanged. `start` held high → next transmission accepted one clk after `done`, using the newly latched inputs.
- **Abort:** `reset` asserted at clk 1000 of a frame → outputs 0 within the same cycle (asynchronous). A subsequent `start` yields a full, correct frame from trit 0.
